// File: rtl/mtr_pwm_drv.sv
// Dual H-bridge PWM driver: one shared period counter and an independent direction FSM per wheel.
// Direction swaps always pass through whole dead periods so a bridge never has both gates driven.

module mtr_pwm_drv #(
    parameter int unsigned PWM_W    = 11,
    parameter int unsigned DEAD_PER = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [PWM_W-1:0] lft_spd,
    input  logic             lft_rev,
    input  logic [PWM_W-1:0] rght_spd,
    input  logic             rght_rev,
    output logic             lft_fwd_pwm,
    output logic             lft_rev_pwm,
    output logic             rght_fwd_pwm,
    output logic             rght_rev_pwm,
    output logic             pwm_synch,
    output logic             dead_lft,
    output logic             dead_rght
);
    localparam int unsigned NCH    = 2;
    localparam int unsigned DCNT_W = 4;
    localparam logic [DCNT_W-1:0] DEAD_LOAD = DCNT_W'(DEAD_PER - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_REV  = 2'd2,
        ST_DEAD = 2'd3
    } state_t;

    logic [PWM_W-1:0] cnt;
    logic             cap_c;
    logic [PWM_W-1:0] spd_in [NCH];
    logic             rev_in [NCH];
    logic             fwd_q  [NCH];
    logic             rev_q  [NCH];
    logic             dead_q [NCH];

    // Free-running period counter; wraps with no stall and ignores en.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PWM_W'(1);
        end
    end

    // Last count of the period doubles as the command capture edge.
    assign cap_c     = (cnt == {PWM_W{1'b1}});
    assign pwm_synch = cap_c;

    assign spd_in[0] = lft_spd;
    assign rev_in[0] = lft_rev;
    assign spd_in[1] = rght_spd;
    assign rev_in[1] = rght_rev;

    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        state_t            state;
        state_t            state_nxt;
        logic [DCNT_W-1:0] dead_cnt;
        logic [DCNT_W-1:0] dead_cnt_nxt;
        logic [PWM_W-1:0]  spd_q;
        logic [PWM_W-1:0]  spd_nxt;
        logic              want_rev;
        logic              on;
        logic              fwd_nxt;
        logic              rev_nxt;

        always_ff @(posedge clk) begin
            if (rst) begin
                state      <= ST_IDLE;
                dead_cnt   <= '0;
                spd_q      <= '0;
                fwd_q[ch]  <= 1'b0;
                rev_q[ch]  <= 1'b0;
                dead_q[ch] <= 1'b0;
            end else begin
                state      <= state_nxt;
                dead_cnt   <= dead_cnt_nxt;
                spd_q      <= spd_nxt;
                fwd_q[ch]  <= fwd_nxt;
                rev_q[ch]  <= rev_nxt;
                dead_q[ch] <= (state_nxt == ST_DEAD);
            end
        end

        // Direction FSM plus gated compare; pulse is high for cnt = 1..spd_q after the register.
        always_comb begin
            state_nxt    = state;
            dead_cnt_nxt = dead_cnt;
            spd_nxt      = cap_c ? spd_in[ch] : spd_q;
            want_rev     = rev_in[ch];
            on           = (cnt < spd_q);
            fwd_nxt      = en && (state == ST_FWD) && on;
            rev_nxt      = en && (state == ST_REV) && on;

            if (!en) begin
                state_nxt    = ST_IDLE;
                dead_cnt_nxt = '0;
            end else if (cap_c) begin
                case (state)
                    ST_IDLE: begin
                        state_nxt = want_rev ? ST_REV : ST_FWD;
                    end
                    ST_FWD: begin
                        if (want_rev) begin
                            state_nxt    = ST_DEAD;
                            dead_cnt_nxt = DEAD_LOAD;
                        end
                    end
                    ST_REV: begin
                        if (!want_rev) begin
                            state_nxt    = ST_DEAD;
                            dead_cnt_nxt = DEAD_LOAD;
                        end
                    end
                    ST_DEAD: begin
                        // Exit follows the newest command, so a cancelled reversal returns home.
                        if (dead_cnt == '0) begin
                            state_nxt = want_rev ? ST_REV : ST_FWD;
                        end else begin
                            dead_cnt_nxt = dead_cnt - DCNT_W'(1);
                        end
                    end
                    default: begin
                        state_nxt = ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign lft_fwd_pwm  = fwd_q[0];
    assign lft_rev_pwm  = rev_q[0];
    assign rght_fwd_pwm = fwd_q[1];
    assign rght_rev_pwm = rev_q[1];
    assign dead_lft     = dead_q[0];
    assign dead_rght    = dead_q[1];

endmodule

// File: doc/mtr_pwm_drv.md
Name: mtr_pwm_drv

Overview:
- Consumes the per-wheel speed/direction commands from the balance controller (11-bit unsigned magnitude plus reverse bit for each wheel).
- Generates forward/reverse PWM gate signals for the left and right H-bridges.
- Commands are latched only at PWM period boundaries, and a forward/reverse swap is always separated by a dead period, so both bridge halves are never driven together.
- Issues a period-boundary strobe that upstream logic uses as a update-timing reference.

Parameters:
- PWM_W, 11: width of speed inputs and of the PWM period counter; period = 2^PWM_W clocks.
- DEAD_PER, 1: number of full PWM periods held low on a direction reversal; legal range 1..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; single clock clk, reset rst is synchronous and active-high.
- en  in  1  drive enable (power-up qualified); low forces all PWM outputs low.
- lft_spd  in  PWM_W  left wheel speed magnitude.
- lft_rev  in  1  left direction, 1 = reverse.
- rght_spd  in  PWM_W  right wheel speed magnitude.
- rght_rev  in  1  right direction, 1 = reverse.
- lft_fwd_pwm  out  1  left bridge forward gate.
- lft_rev_pwm  out  1  left bridge reverse gate.
- rght_fwd_pwm  out  1  right bridge forward gate.
- rght_rev_pwm  out  1  right bridge reverse gate.
- pwm_synch  out  1  high for exactly the one cycle in which cnt == 2^PWM_W-1.
- dead_lft  out  1  high while left channel is in DEAD state.
- dead_rght  out  1  high while right channel is in DEAD state.

Behaviour:
- Reset (rst high at clk edge):
  - cnt, latched speeds and dead counters go to 0.
  - Both channel FSMs go to IDLE.
  - All outputs are 0 after that edge.
  - Reset wins over every other event, including mid-pulse.
- cnt:
  - Free-running PWM_W-bit counter; increments every clock.
  - Wraps 2047 to 0 with no stall.
  - Runs regardless of en.
  - pwm_synch is decoded combinationally from cnt.
- Capture edge = the clk edge at which pwm_synch is high:
  - spd_q <= *_spd and rev_q <= *_rev for each channel.
  - Inputs are ignored at all other edges; mid-period input changes have no effect on the current period.
- Registered compare:
  - Each edge, the active-direction output <= (cnt < spd_q), gated by state; the inactive-direction output <= 0.
  - Result: high during cycles where cnt = 1..spd_q, i.e. exactly spd_q high cycles per 2048-cycle period (one clock of latency).
  - spd_q = 0 gives constant low; spd_q = 0x7FF gives 2047 high / 1 low.
- Channel FSM (identical, independent per wheel):
  - IDLE: outputs low. At capture edge with en=1, go to FWD if captured rev=0, else REV. No dead period is needed because the outputs were already low.
  - FWD: only *_fwd_pwm may pulse. At capture edge with captured rev=1: go to DEAD and set dead_cnt = DEAD_PER-1.
  - REV: mirror of FWD.
  - DEAD: both outputs low; dead_* = 1. At each capture edge, if dead_cnt == 0, go to the direction of the rev value captured at that edge; otherwise decrement dead_cnt.
- DEAD exit target is always the latest captured rev:
  - A reversal that is cancelled during DEAD still completes the dead period, then returns to the original direction.
- en low at any edge:
  - FSM goes to IDLE, dead_cnt is cleared, and all PWM outputs are 0 after that edge, regardless of cnt position.
  - Re-assertion takes effect only at the next capture edge.
- Invariant: *_fwd_pwm & *_rev_pwm == 0 on every cycle.
- Invariant: a channel never goes FWD to REV (or REV to FWD) without passing through at least DEAD_PER full periods with both outputs low.
- Channels share cnt and pwm_synch but have no other coupling; simultaneous reversals on both wheels are handled independently.

Test Plan:
- rst 3 cycles, en=1, lft_spd=0x400, lft_rev=0, rght_spd=0x100, rght_rev=1 -> from the first capture edge onward:
  - lft_fwd_pwm: 1024 high / 1024 low per 2048 cycles.
  - rght_rev_pwm: 256 high per period.
  - lft_rev_pwm and rght_fwd_pwm constantly 0.
  - pwm_synch: one cycle every 2048.
- lft_spd=0 then 0x7FF -> a period with zero high cycles, then 2047 high / 1 low; the change never appears mid-period.
- Running FWD at 0x200, toggle lft_rev=1 at cnt=500 ->
  - The current period keeps 512 fwd high cycles.
  - The next period has both outputs low with dead_lft=1.
  - The following period gives lft_rev_pwm 512 high.
- Reversal then lft_rev back to 0 during DEAD -> one full dead period, then FWD resumes at the captured speed; rev_pwm never pulses.
- en low at cnt=100 during a high pulse -> all PWM 0 next cycle. en high again -> restart at the next capture edge with no dead period.
- rst asserted mid-pulse in REV -> outputs 0 and cnt 0 after the edge; pwm_synch reappears 2047 cycles after rst deasserts.
